// File: rtl/sq_cub_sum_pkg.sv
// Shared encodings and widths for the a^2 + cbrt(b) block and its squarer.
package sq_cub_sum_pkg;

    localparam int A_W = 8;
    localparam int B_W = 9;
    localparam int C_W = 3;
    localparam int Y_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CUB_RST = 3'd1,
        LAUNCH  = 3'd2,
        WAIT    = 3'd3,
        SUM     = 3'd4,
        DONE    = 3'd5
    } state_t;

    // True for every state between accepting an operation and presenting it.
    function automatic logic is_busy(input state_t s);
        return (s == CUB_RST) || (s == LAUNCH) || (s == WAIT) || (s == SUM);
    endfunction

endpackage

// File: rtl/sq_cub_sum_sqr8.sv
// 8x8 iterative squarer: one bit of a per cycle, LSB first, 16-bit accumulator.
module sqr8
    import sq_cub_sum_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [A_W-1:0] a_bi,
    output logic           ready_o,
    output logic [Y_W-1:0] y_bo
);

    logic [Y_W-1:0] acc_r;
    logic [Y_W-1:0] mcand_r;
    logic [A_W-1:0] mult_r;
    logic [2:0]     iter_r;
    logic           run_r;

    // The load cycle performs the first iteration; seven more follow, ready after the eighth.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc_r   <= '0;
            mcand_r <= '0;
            mult_r  <= '0;
            iter_r  <= '0;
            run_r   <= 1'b0;
            ready_o <= 1'b0;
        end else if (start_i) begin
            acc_r   <= a_bi[0] ? {{(Y_W-A_W){1'b0}}, a_bi} : '0;
            mcand_r <= {{(Y_W-A_W-1){1'b0}}, a_bi, 1'b0};
            mult_r  <= {1'b0, a_bi[A_W-1:1]};
            iter_r  <= 3'd1;
            run_r   <= 1'b1;
            ready_o <= 1'b0;
        end else if (run_r) begin
            if (mult_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end
            mcand_r <= {mcand_r[Y_W-2:0], 1'b0};
            mult_r  <= {1'b0, mult_r[A_W-1:1]};
            iter_r  <= iter_r + 3'd1;
            if (iter_r == 3'd7) begin
                run_r   <= 1'b0;
                ready_o <= 1'b1;
            end
        end
    end

    assign y_bo = acc_r;

endmodule

// File: rtl/sq_cub_sum.sv
// Computes a^2 + cbrt(b): drives the external cube-root unit while sqr8 squares a in parallel.
module sq_cub_sum
    import sq_cub_sum_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [A_W-1:0] a_bi,
    input  logic [B_W-1:0] b_bi,
    input  logic           start_i,
    output logic           busy_o,
    output logic           ready_o,
    output logic           err_o,
    output logic [Y_W-1:0] y_bo,
    output logic           cub_rst_no,
    output logic           cub_start_o,
    output logic [B_W-1:0] cub_x_o,
    input  logic           cub_ready_i,
    input  logic [C_W-1:0] cub_y_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t         state_q;
    state_t         state_d;
    logic [A_W-1:0] a_r;
    logic [B_W-1:0] b_r;
    logic [C_W-1:0] c_r;
    logic           c_valid_r;
    logic [CNT_W-1:0] tmo_cnt;
    logic           cub_done;
    logic           tmo_hit;
    logic           sq_ready;
    logic [Y_W-1:0] sq_y;

    // The cube root counts as done either once captured or in the very cycle it arrives.
    assign cub_done = c_valid_r | cub_ready_i;

    // Only time the wait while the cube root is still outstanding.
    assign tmo_hit = (state_q == WAIT) && !cub_ready_i && !c_valid_r &&
                     (tmo_cnt == CNT_W'(TIMEOUT - 1));

    sqr8 u_sqr8 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (state_q == CUB_RST),
        .a_bi    (a_r),
        .ready_o (sq_ready),
        .y_bo    (sq_y)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is honoured only in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = CUB_RST;
            CUB_RST: state_d = LAUNCH;
            LAUNCH:  state_d = WAIT;
            WAIT: begin
                if (tmo_hit) begin
                    state_d = DONE;
                end else if (cub_done && sq_ready) begin
                    state_d = SUM;
                end
            end
            SUM:     state_d = DONE;
            DONE:    if (start_i) state_d = CUB_RST;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, cube-root capture, timeout counter and the final sum.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            a_r       <= '0;
            b_r       <= '0;
            c_r       <= '0;
            c_valid_r <= 1'b0;
            tmo_cnt   <= '0;
            y_bo      <= '0;
            err_o     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        a_r       <= a_bi;
                        b_r       <= b_bi;
                        c_valid_r <= 1'b0;
                        err_o     <= 1'b0;
                        y_bo      <= '0;
                    end
                end
                LAUNCH: begin
                    tmo_cnt   <= '0;
                    c_valid_r <= 1'b0;
                end
                WAIT: begin
                    if (cub_ready_i) begin
                        c_r       <= cub_y_i;
                        c_valid_r <= 1'b1;
                    end else if (!c_valid_r) begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                    if (tmo_hit) begin
                        err_o <= 1'b1;
                        y_bo  <= '0;
                    end
                end
                SUM: begin
                    y_bo <= sq_y + {{(Y_W-C_W){1'b0}}, c_r};
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o      = is_busy(state_q);
    assign ready_o     = (state_q == DONE);
    assign cub_start_o = (state_q == LAUNCH);
    assign cub_x_o     = b_r;
    assign cub_rst_no  = rst_i & (state_q != CUB_RST);

endmodule

// File: tb/tb_sq_cub_sum.sv
// Directed bench for sq_cub_sum with a behavioural cube-root unit of programmable latency.
module tb_sq_cub_sum;

    localparam int MAX_CYC = 400;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [8:0] b;
    logic       start;

    logic        busy, ready, err;
    logic [15:0] y;
    logic        cub_rst_n, cub_start;
    logic [8:0]  cub_x;
    logic        cub_ready;
    logic [2:0]  cub_y;

    logic        start_to, busy_to, ready_to, err_to;
    logic [15:0] y_to;
    logic        cub_rst_n_to, cub_start_to;
    logic [8:0]  cub_x_to;

    int   stub_lat;
    logic stub_stuck;

    logic       m_ready, m_busy;
    logic [8:0] m_x;
    logic [2:0] m_y;
    int         m_cnt;

    int checks;
    int errors;

    typedef struct {
        logic [7:0]  a;
        logic [8:0]  b;
        int          lat;
        logic [15:0] y_exp;
        int          cyc_exp;
    } vec_t;

    vec_t vecs[9];

    sq_cub_sum dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .a_bi        (a),
        .b_bi        (b),
        .start_i     (start),
        .busy_o      (busy),
        .ready_o     (ready),
        .err_o       (err),
        .y_bo        (y),
        .cub_rst_no  (cub_rst_n),
        .cub_start_o (cub_start),
        .cub_x_o     (cub_x),
        .cub_ready_i (cub_ready),
        .cub_y_i     (cub_y)
    );

    sq_cub_sum #(.TIMEOUT(20)) dut_to (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .a_bi        (a),
        .b_bi        (b),
        .start_i     (start_to),
        .busy_o      (busy_to),
        .ready_o     (ready_to),
        .err_o       (err_to),
        .y_bo        (y_to),
        .cub_rst_no  (cub_rst_n_to),
        .cub_start_o (cub_start_to),
        .cub_x_o     (cub_x_to),
        .cub_ready_i (1'b0),
        .cub_y_i     (3'd0)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [2:0] cbrt9(input logic [8:0] x);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (i * i * i <= int'(x)) r = 3'(i);
        end
        return r;
    endfunction

    // Cube-root unit model: stays READY until reset, answers stub_lat edges after sampling start.
    always @(posedge clk or negedge cub_rst_n) begin
        if (!cub_rst_n) begin
            m_ready <= 1'b0;
            m_busy  <= 1'b0;
            m_cnt   <= 0;
            m_y     <= 3'd0;
            m_x     <= 9'd0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_ready <= 1'b1;
                m_busy  <= 1'b0;
                m_y     <= cbrt9(m_x);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (cub_start && !m_ready) begin
            m_x    <= cub_x;
            m_busy <= 1'b1;
            m_cnt  <= stub_lat - 1;
        end
    end

    assign cub_ready = m_ready & ~stub_stuck;
    assign cub_y     = m_y;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic wait_ready(inout int cyc);
        while (!ready && cyc < MAX_CYC) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Launch one operation and follow it to ready, recording the cub handshake.
    task automatic apply_stimulus(input logic [7:0] av, input logic [8:0] bv,
                                  output int cyc, output int rst_low, output int rst_first,
                                  output int start_cnt, output int start_first,
                                  output logic [8:0] x_seen);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~av;
        b = ~bv;
        cyc = 0;
        rst_low = 0;
        rst_first = -1;
        start_cnt = 0;
        start_first = -1;
        x_seen = '0;
        while (!ready && cyc < MAX_CYC) begin
            if (!cub_rst_n) begin
                rst_low++;
                if (rst_first < 0) rst_first = cyc;
            end
            if (cub_start) begin
                start_cnt++;
                x_seen = cub_x;
                if (start_first < 0) start_first = cyc;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc, rst_low, rst_first, start_cnt, start_first;
        logic [8:0] x_seen;

        checks = 0;
        errors = 0;
        vecs[0] = '{8'd0,   9'd0,   3,  16'd0,     10};
        vecs[1] = '{8'd3,   9'd27,  3,  16'd12,    10};
        vecs[2] = '{8'd10,  9'd8,   4,  16'd102,   10};
        vecs[3] = '{8'd255, 9'd511, 5,  16'd65032, 10};
        vecs[4] = '{8'd5,   9'd1,   2,  16'd26,    10};
        vecs[5] = '{8'd7,   9'd100, 40, 16'd53,    44};
        vecs[6] = '{8'd12,  9'd343, 6,  16'd151,   10};
        vecs[7] = '{8'd1,   9'd342, 7,  16'd7,     11};
        vecs[8] = '{8'd128, 9'd64,  1,  16'd16388, 10};

        rst_n = 1'b0;
        a = '0;
        b = '0;
        start = 1'b0;
        start_to = 1'b0;
        stub_lat = 3;
        stub_stuck = 1'b0;

        #3;
        check_output("reset ready", int'(ready), 0);
        check_output("reset busy", int'(busy), 0);
        check_output("reset err", int'(err), 0);
        check_output("reset y", int'(y), 0);
        check_output("reset cub_start", int'(cub_start), 0);
        check_output("reset cub_x", int'(cub_x), 0);
        check_output("reset cub_rst_n", int'(cub_rst_n), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("idle cub_rst_n", int'(cub_rst_n), 1);
        check_output("idle busy", int'(busy), 0);

        for (int i = 0; i < 9; i++) begin
            stub_lat = vecs[i].lat;
            apply_stimulus(vecs[i].a, vecs[i].b, cyc, rst_low, rst_first, start_cnt, start_first, x_seen);
            $display("[TB] vec %0d a=%0d b=%0d lat=%0d -> y=%0d after %0d cycles",
                     i, vecs[i].a, vecs[i].b, vecs[i].lat, y, cyc);
            check_output($sformatf("vec%0d y", i), int'(y), int'(vecs[i].y_exp));
            check_output($sformatf("vec%0d err", i), int'(err), 0);
            check_output($sformatf("vec%0d latency", i), cyc, vecs[i].cyc_exp);
            check_output($sformatf("vec%0d cub_rst_n low cycles", i), rst_low, 1);
            check_output($sformatf("vec%0d cub_rst_n low at", i), rst_first, 0);
            check_output($sformatf("vec%0d cub_start cycles", i), start_cnt, 1);
            check_output($sformatf("vec%0d cub_start at", i), start_first, 1);
            check_output($sformatf("vec%0d cub_x", i), int'(x_seen), int'(vecs[i].b));
        end

        // start held high through WAIT with new operands must not disturb the running op
        stub_lat = 4;
        a = 8'd9;
        b = 9'd27;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'd200;
        b = 9'd500;
        cyc = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        wait_ready(cyc);
        check_output("held start y", int'(y), 84);
        check_output("held start latency", cyc, 10);

        // start from DONE goes straight to CUB_RST
        a = 8'd2;
        b = 9'd64;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output("done restart busy", int'(busy), 1);
        check_output("done restart cub_rst_n", int'(cub_rst_n), 0);
        cyc = 0;
        wait_ready(cyc);
        check_output("done restart y", int'(y), 8);

        // asynchronous reset during WAIT
        stub_lat = 40;
        a = 8'd50;
        b = 9'd125;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check_output("pre-reset busy", int'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("async reset busy", int'(busy), 0);
        check_output("async reset ready", int'(ready), 0);
        check_output("async reset y", int'(y), 0);
        check_output("async reset cub_rst_n", int'(cub_rst_n), 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        stub_lat = 3;
        apply_stimulus(8'd50, 9'd125, cyc, rst_low, rst_first, start_cnt, start_first, x_seen);
        check_output("post-reset y", int'(y), 2505);
        check_output("post-reset latency", cyc, 10);

        // stuck cube root on the TIMEOUT=20 instance
        a = 8'd3;
        b = 9'd27;
        start_to = 1'b1;
        @(posedge clk);
        #1;
        start_to = 1'b0;
        cyc = 0;
        while (!ready_to && cyc < MAX_CYC) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_output("timeout latency", cyc, 22);
        check_output("timeout err", int'(err_to), 1);
        check_output("timeout y", int'(y_to), 0);
        start_to = 1'b1;
        @(posedge clk);
        #1;
        start_to = 1'b0;
        check_output("timeout restart err", int'(err_to), 0);
        check_output("timeout restart busy", int'(busy_to), 1);
        cyc = 0;
        while (!ready_to && cyc < MAX_CYC) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_output("timeout again err", int'(err_to), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so a broken design can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
